cg_phase_sequencer: RTL and testbench

Top-level iteration scheduler for the conjugate-gradient datapath. It steps the shared ALU/memory datapath through the CG phases of each iteration: A*P, dot(P,AP), X/R update, dot(R,R), P update, then the convergence check. In each phase it issues a start pulse, sweeps the vector read address over all words, and waits for the datapath's done. It owns iteration counting and halt, and feeds the memory address control logic.

---
 rtl/cg_ctrl_pkg.sv | 17 +
 rtl/cg_sweep_counter.sv | 33 +++
 rtl/cg_phase_sequencer.sv | 96 +++++++++
 tb/tb_cg_phase_sequencer.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/cg_ctrl_pkg.sv
// cg_ctrl_pkg: phase encoding and sizing helpers shared by the CG sequencer files
package cg_ctrl_pkg;
    typedef enum logic [2:0] {
        PH_IDLE      = 3'd0,
        PH_MATVEC    = 3'd1,
        PH_DOT_PAP   = 3'd2,
        PH_UPDATE_XR = 3'd3,
        PH_DOT_RR    = 3'd4,
        PH_UPDATE_P  = 3'd5,
        PH_CHECK     = 3'd6,
        PH_DONE      = 3'd7
    } phase_e;
    localparam int ITER_WIDTH_DEF = 11;
    function automatic logic [31:0] depth_of(input logic [31:0] total, input int units);
        return total / 32'(units);
    endfunction
endpackage

// File: rtl/cg_sweep_counter.sv
// cg_sweep_counter: walks a vector read address from 0 to depth-1, holding while stalled
module cg_sweep_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] depth,
    input  logic         stall,
    output logic [W-1:0] address,
    output logic         valid,
    output logic         complete
);
    logic running;
    logic last;
    assign valid = running && !stall;
    assign last = address == depth - W'(1);
    always_ff @(posedge clk) begin
        if (reset) begin
            address  <= '0;
            running  <= 1'b0;
            complete <= 1'b0;
        end else if (load) begin
            address  <= '0;
            running  <= 1'b1;
            complete <= 1'b0;
        end else if (valid) begin
            address  <= last ? '0 : address + W'(1);
            running  <= !last;
            complete <= last;
        end
    end
endmodule

// File: rtl/cg_phase_sequencer.sv
// cg_phase_sequencer: steps the CG datapath through its per-iteration phases and owns iteration/halt control
module cg_phase_sequencer
    import cg_ctrl_pkg::*;
#(
    parameter int NO_OF_UNITS    = 8,
    parameter int ADDRESS_WIDTH  = 32,
    parameter int MAX_ITERATIONS = 3,
    parameter int ITER_WIDTH     = ITER_WIDTH_DEF
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     abort,
    input  logic [31:0]              total,
    input  logic                     converged,
    input  logic                     phase_done,
    input  logic                     read_stall,
    output logic [2:0]               phase,
    output logic                     phase_start,
    output logic [ADDRESS_WIDTH-1:0] read_address,
    output logic                     read_valid,
    output logic                     busy,
    output logic                     halt,
    output logic [ITER_WIDTH-1:0]    iteration_count,
    output logic                     cfg_error
);
    localparam int IW = ITER_WIDTH + 1;
    phase_e state, next;
    logic [31:0] req_depth, depth;
    logic [ITER_WIDTH:0] iter_plus;
    logic [ITER_WIDTH-1:0] iter_inc;
    logic idle_or_done, in_sweep_phase, accept, reject, last_iter, enter, done_flag, complete;

    assign req_depth = depth_of(total, NO_OF_UNITS);
    assign idle_or_done = state == PH_IDLE || state == PH_DONE;
    assign in_sweep_phase = state >= PH_MATVEC && state <= PH_UPDATE_P;
    assign accept = !abort && start && idle_or_done && req_depth != '0;
    assign reject = !abort && start && idle_or_done && req_depth == '0;
    // the carry out of iter_plus marks an all-ones count, which must saturate
    assign iter_plus = {1'b0, iteration_count} + IW'(1);
    assign iter_inc = iter_plus[ITER_WIDTH] ? iteration_count : iter_plus[ITER_WIDTH-1:0];
    assign last_iter = converged || iter_plus == IW'(MAX_ITERATIONS);
    assign enter = next != state && next >= PH_MATVEC && next <= PH_UPDATE_P;

    cg_sweep_counter #(.W(ADDRESS_WIDTH)) sweep (
        .clk      (clk),
        .reset    (reset || abort),
        .load     (enter),
        .depth    (ADDRESS_WIDTH'(depth)),
        .stall    (read_stall),
        .address  (read_address),
        .valid    (read_valid),
        .complete (complete)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= PH_IDLE;
        else state <= next;
    end

    always_comb begin
        next = state;
        if (abort) next = PH_IDLE;
        else if (idle_or_done) next = accept ? PH_MATVEC : state;
        else if (state == PH_CHECK) next = last_iter ? PH_DONE : PH_MATVEC;
        else if (complete && done_flag) next = phase_e'(state + 3'd1);
    end

    always_comb begin
        phase = state;
        busy  = !idle_or_done;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            depth           <= '0;
            done_flag       <= 1'b0;
            phase_start     <= 1'b0;
            cfg_error       <= 1'b0;
            halt            <= 1'b0;
            iteration_count <= '0;
        end else begin
            phase_start <= enter;
            cfg_error   <= reject;
            done_flag   <= next != state ? 1'b0 : done_flag || (phase_done && in_sweep_phase);
            if (accept) begin
                depth           <= req_depth;
                halt            <= 1'b0;
                iteration_count <= '0;
            end else if (state == PH_CHECK && !abort) begin
                halt            <= last_iter;
                iteration_count <= iter_inc;
            end
        end
    end
endmodule

// File: tb/tb_cg_phase_sequencer.sv
// tb_cg_phase_sequencer: randomized scoreboard bench for the CG phase sequencer
module tb_cg_phase_sequencer;
    logic        clk, reset, start, abort, converged, phase_done, read_stall;
    logic [31:0] total;
    logic [2:0]  phase;
    logic        phase_start, read_valid, busy, halt, cfg_error;
    logic [31:0] read_address;
    logic [10:0] iteration_count;

    int checks = 0, passes = 0;
    logic [34:0] exp_q[$];
    logic [2:0]  ps_q[$];
    int resp_en = 0, stall_en = 0, fixed_cd = -1, cur_depth = 8, conv_iter = 4;
    int mv_count = 0, mv_base = 0, cd = -1, exp_iters = 0, exp_cycles = -1;

    cg_phase_sequencer #(
        .NO_OF_UNITS(8), .ADDRESS_WIDTH(32), .MAX_ITERATIONS(3), .ITER_WIDTH(11)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort), .total(total),
        .converged(converged), .phase_done(phase_done), .read_stall(read_stall),
        .phase(phase), .phase_start(phase_start), .read_address(read_address),
        .read_valid(read_valid), .busy(busy), .halt(halt),
        .iteration_count(iteration_count), .cfg_error(cfg_error)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act === req) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, act, req);
    endtask

    task automatic fail_now(input string name);
        checks++;
        $display("FAIL %s: event did not occur within bound", name);
    endtask

    // datapath stand-in: answers each phase with one phase_done, random stalls, and convergence
    initial begin
        phase_done = 0;
        read_stall = 0;
        converged  = 0;
        forever begin
            @(posedge clk); #1;
            if (resp_en == 0) cd = -1;
            else if (phase_start) begin
                if (phase == 3'd1) mv_count++;
                cd = fixed_cd >= 0 ? fixed_cd : int'($urandom_range(0, cur_depth + 4));
            end
            phase_done = resp_en != 0 && cd == 0;
            if (cd >= 0) cd--;
            read_stall = resp_en != 0 && stall_en != 0 && $urandom_range(0, 3) == 0;
            converged  = resp_en != 0 && (mv_count - mv_base) >= conv_iter;
        end
    end

    initial begin
        logic [34:0] e;
        logic [2:0]  p;
        forever begin
            @(negedge clk);
            if (read_valid) begin
                if (exp_q.size() == 0) fail_now("read_unexpected");
                else begin
                    e = exp_q.pop_front();
                    check("read_word", {phase, read_address}, e);
                end
            end
            if (phase_start) begin
                if (ps_q.size() == 0) fail_now("start_unexpected");
                else begin
                    p = ps_q.pop_front();
                    check("phase_start", {phase, read_address}, {p, 32'd0});
                end
            end
            if (read_stall && busy) check("stall_gap", read_valid, 1'b0);
        end
    end

    task automatic launch(input int tot, input int conv, input int stl, input int fcd);
        int d, it;
        d = tot / 8;
        it = conv < 3 ? conv : 3;
        cur_depth = d; conv_iter = conv; stall_en = stl; fixed_cd = fcd;
        mv_base = mv_count; resp_en = 1; exp_iters = it;
        exp_cycles = (fcd >= 0 && stl == 0) ? it * (5 * ((d > fcd + 1 ? d : fcd + 1) + 1) + 1) : -1;
        for (int i = 0; i < it; i++)
            for (int p = 1; p <= 5; p++) begin
                ps_q.push_back(3'(p));
                for (int a = 0; a < d; a++) exp_q.push_back({3'(p), 32'(a)});
            end
        total = 32'(tot);
        start = 1;
        @(posedge clk); #1;
        start = 0;
    endtask

    task automatic finish_solve(input string tag);
        int n = 0;
        while (!halt && n < 3000) begin
            @(posedge clk); #1;
            n++;
        end
        if (!halt) begin
            fail_now({tag, "_halt"});
            return;
        end
        check({tag, "_phase"}, phase, 3'd7);
        check({tag, "_iters"}, iteration_count, exp_iters);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_reads_left"}, exp_q.size(), 0);
        check({tag, "_starts_left"}, ps_q.size(), 0);
        if (exp_cycles >= 0) check({tag, "_cycles"}, n, exp_cycles);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_phase"}, phase, 3'd0);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_halt"}, halt, 1'b0);
        check({tag, "_iters"}, iteration_count, 0);
        check({tag, "_valid"}, read_valid, 1'b0);
        check({tag, "_addr"}, read_address, 0);
        check({tag, "_pstart"}, phase_start, 1'b0);
        check({tag, "_cfgerr"}, cfg_error, 1'b0);
    endtask

    initial begin
        int n;
        reset = 1; start = 0; abort = 0; total = 0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        reset = 0;

        total = 5; start = 1;
        @(posedge clk); #1;
        start = 0;
        check("cfg_pulse", cfg_error, 1'b1);
        check("cfg_phase", phase, 3'd0);
        check("cfg_busy", busy, 1'b0);
        @(posedge clk); #1;
        check("cfg_clear", cfg_error, 1'b0);

        launch(64, 4, 0, 11);
        finish_solve("late_done");
        abort = 1;
        @(posedge clk); #1;
        abort = 0;
        check("abort_done_phase", phase, 3'd0);
        check("abort_done_halt", halt, 1'b1);
        check("abort_done_iters", iteration_count, 3);

        launch(64, 1, 0, 3);
        finish_solve("converged");
        launch(64, 4, 0, 2);
        finish_solve("early_done");
        for (int k = 0; k < 6; k++) begin
            launch($urandom_range(8, 88), $urandom_range(1, 4), $urandom_range(0, 1), -1);
            finish_solve("random");
        end

        launch(64, 4, 0, 11);
        n = 0;
        while (!(phase_start && phase == 3'd4 && mv_count - mv_base == 2) && n < 3000) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 3000) fail_now("reach_dot_rr");
        start = 1;
        @(posedge clk); #1;
        start = 0;
        check("busy_start_phase", phase, 3'd4);
        check("busy_start_iters", iteration_count, 1);
        abort = 1;
        @(posedge clk); #1;
        abort = 0;
        resp_en = 0;
        check("abort_phase", phase, 3'd0);
        check("abort_busy", busy, 1'b0);
        check("abort_valid", read_valid, 1'b0);
        check("abort_iters", iteration_count, 1);
        check("abort_halt", halt, 1'b0);
        exp_q.delete();
        ps_q.delete();

        launch(64, 4, 1, -1);
        n = 0;
        while (!(phase == 3'd3 && read_valid && read_address == 2) && n < 3000) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 3000) fail_now("reach_update_xr");
        reset = 1;
        @(posedge clk); #1;
        resp_en = 0;
        check_all_zero("mid_reset");
        reset = 0;
        exp_q.delete();
        ps_q.delete();

        launch(16, 2, 1, -1);
        finish_solve("recover");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
